// File: rtl/puf_scan_pkg.sv
// Shared types and defaults for the arbiter-PUF scan controller.
package puf_scan_pkg;

  localparam int unsigned W_DEFAULT      = 128;
  localparam int unsigned PH_DIV_DEFAULT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TRIG,
    ST_SETTLE,
    ST_UNLOAD,
    ST_DONE
  } state_t;

  // Slots within one bit period: gap, PH1 high, gap, PH2 high.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } slot_t;

endpackage

// File: rtl/puf_phase_gen.sv
// Slot / bit-period sequencer producing the non-overlapping PH1/PH2 phase clocks.
module puf_phase_gen
  import puf_scan_pkg::*;
#(
  parameter int unsigned PH_DIV = PH_DIV_DEFAULT
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  output logic  ph1,
  output logic  ph2,
  output slot_t slot,
  output logic  slot_end,
  output logic  period_end
);

  localparam int unsigned DW = (PH_DIV > 1) ? $clog2(PH_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PH_DIV - 1);

  logic [DW-1:0] div_cnt;

  // Counters sit at S0/0 while disabled so every LOAD/UNLOAD starts on a period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      slot    <= S0;
    end else if (!en) begin
      div_cnt <= '0;
      slot    <= S0;
    end else if (slot_end) begin
      div_cnt <= '0;
      slot    <= slot_t'(slot + 2'd1);
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign slot_end   = (div_cnt == DIV_LAST);
  assign period_end = en && slot_end && (slot == S3);
  assign ph1        = en && (slot == S1);
  assign ph2        = en && (slot == S3);

endmodule

// File: rtl/puf_scan_controller.sv
// Host-side arbiter-PUF driver: serial challenge load, trigger, serial response unload.
module puf_scan_controller
  import puf_scan_pkg::*;
#(
  parameter int unsigned W             = W_DEFAULT,
  parameter int unsigned PH_DIV        = PH_DIV_DEFAULT,
  parameter int unsigned TRIG_CYCLES   = 8,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] chal_a,
  input  logic [W-1:0] chal_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] resp_up,
  output logic [W-1:0] resp_down,
  output logic         err,
  output logic         PH1,
  output logic         PH2,
  output logic         CA_SI,
  output logic         CB_SI,
  output logic         Ph_En,
  output logic         OutEn,
  output logic         Trig,
  input  logic         SO_Up,
  input  logic         SO_not_Up,
  input  logic         SO_Down,
  input  logic         SO_not_Down
);

  localparam int unsigned IW   = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned BW   = IW + 1;
  localparam int unsigned MAXC = (TRIG_CYCLES > SETTLE_CYCLES) ? TRIG_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [BW-1:0] BIT_LAST    = BW'(W - 1);
  localparam logic [CW-1:0] TRIG_LAST   = CW'(TRIG_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  state_t        state, next_state;
  logic [W-1:0]  chal_a_q, chal_b_q;
  logic [BW-1:0] bit_cnt;
  logic [IW-1:0] bit_idx;
  logic [CW-1:0] cyc_cnt;
  logic [3:0]    so_meta, so_sync;
  logic          phase_en, ph1, ph2, slot_end, period_end, last_period, sample;
  slot_t         slot;

  puf_phase_gen #(.PH_DIV(PH_DIV)) u_phase_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (phase_en),
    .ph1        (ph1),
    .ph2        (ph2),
    .slot       (slot),
    .slot_end   (slot_end),
    .period_end (period_end)
  );

  assign phase_en    = (state == ST_LOAD) || (state == ST_UNLOAD);
  assign bit_idx     = bit_cnt[IW-1:0];
  assign last_period = period_end && (bit_cnt == BIT_LAST);
  assign sample      = (state == ST_UNLOAD) && (slot == S0) && slot_end;

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    Ph_En      = 1'b0;
    OutEn      = 1'b0;
    Trig       = 1'b0;
    case (state)
      ST_IDLE:   if (start) next_state = ST_LOAD;
      ST_LOAD: begin
        busy  = 1'b1;
        Ph_En = 1'b1;
        if (last_period) next_state = ST_TRIG;
      end
      ST_TRIG: begin
        busy = 1'b1;
        Trig = 1'b1;
        if (cyc_cnt == TRIG_LAST) next_state = ST_SETTLE;
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (cyc_cnt == SETTLE_LAST) next_state = ST_UNLOAD;
      end
      ST_UNLOAD: begin
        busy  = 1'b1;
        OutEn = 1'b1;
        if (last_period) next_state = ST_DONE;
      end
      ST_DONE:   begin
        busy       = 1'b1;
        next_state = ST_IDLE;
      end
      default:   next_state = ST_IDLE;
    endcase
  end

  assign PH1   = ph1;
  assign PH2   = ph2;
  assign CA_SI = Ph_En && chal_a_q[bit_idx];
  assign CB_SI = Ph_En && chal_b_q[bit_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      chal_a_q <= '0;
      chal_b_q <= '0;
      so_meta  <= '0;
      so_sync  <= '0;
      resp_up  <= '0;
      resp_down <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      state   <= next_state;
      so_meta <= {SO_Up, SO_not_Up, SO_Down, SO_not_Down};
      so_sync <= so_meta;
      // done is registered so it coincides with the IDLE cycle after DONE.
      done    <= (state == ST_DONE);

      if ((next_state == state) && ((state == ST_TRIG) || (state == ST_SETTLE)))
        cyc_cnt <= cyc_cnt + 1'b1;
      else
        cyc_cnt <= '0;

      if (!phase_en)
        bit_cnt <= '0;
      else if (period_end && (bit_cnt != BIT_LAST))
        bit_cnt <= bit_cnt + 1'b1;

      if ((state == ST_IDLE) && start) begin
        chal_a_q <= chal_a;
        chal_b_q <= chal_b;
        err      <= 1'b0;
      end

      if (sample) begin
        resp_up[bit_idx]   <= so_sync[3];
        resp_down[bit_idx] <= so_sync[1];
        if ((so_sync[3] == so_sync[2]) || (so_sync[1] == so_sync[0]))
          err <= 1'b1;
      end
    end
  end

endmodule
